// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, swap FSM encoding and scan-address helper for the VGA
// framebuffer arbiter.
package vga_fb_arbiter_pkg;

  localparam int unsigned FB_W_DEF = 160;
  localparam int unsigned FB_H_DEF = 120;
  localparam int unsigned DW_DEF   = 8;

  localparam logic [10:0] SWAP_VCOUNT = 11'd480;
  localparam logic [10:0] SWAP_HCOUNT = 11'd0;

  typedef enum logic {
    StIdle    = 1'b0,
    StPending = 1'b1
  } swap_state_e;

  // y*160 + x as shift-add on the 4x-downscaled counters.
  function automatic logic [14:0] scan_index(input logic [10:0] h, input logic [10:0] v);
    logic [14:0] x;
    logic [14:0] y;
    x = 15'(h[10:2]);
    y = 15'(v[10:2]);
    return (y << 7) + (y << 5) + x;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Generic N-stage register delay line with a per-bit reset value.
module vga_sync_delay #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_q[i] <= RESET_VAL;
      end
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[STAGES-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Double-buffered framebuffer port arbiter: scanout reads get every 4th active
// pixel cycle, draw-engine writes take the rest, buffer swaps happen at vblank.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic [10:0]   hcounter,
  input  logic [10:0]   vcounter,
  input  logic          blank,
  input  logic          HS_in,
  input  logic          VS_in,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [14:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          front_buf,
  output logic [15:0]   mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rgb,
  output logic          HS,
  output logic          VS,
  output logic          blank_out
);

  localparam logic [14:0] FB_SIZE = 15'(FB_W * FB_H);

  swap_state_e   state_q, state_d;
  logic          front_buf_q;
  logic          swap_done_q;
  logic          do_swap;
  logic          swap_point;

  logic          scan_slot;
  logic          wr_accept;
  logic          wr_in_range;
  logic [15:0]   addr_q, addr_d;
  logic          we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          slot_q;
  logic [DW-1:0] rgb_q;

  // Port arbitration; address and data hold their last value when the port is idle.
  always_comb begin
    scan_slot   = ~blank & (hcounter[1:0] == 2'b00);
    wr_ready    = ~scan_slot;
    wr_accept   = wr_valid & wr_ready;
    wr_in_range = wr_addr < FB_SIZE;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    if (scan_slot) begin
      addr_d = {front_buf_q, scan_index(hcounter, vcounter)};
    end else if (wr_accept && wr_in_range) begin
      addr_d  = {~front_buf_q, wr_addr};
      wdata_d = wr_data;
      we_d    = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      slot_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      slot_q  <= scan_slot;
      if (slot_q) begin
        rgb_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = rst ? '0 : addr_d;
  assign mem_we    = rst ? 1'b0 : we_d;
  assign mem_wdata = rst ? '0 : wdata_d;

  // Swap FSM: a request coinciding with the swap point is served immediately.
  always_comb begin
    state_d    = state_q;
    do_swap    = 1'b0;
    swap_point = (vcounter == SWAP_VCOUNT) && (hcounter == SWAP_HCOUNT);
    unique case (state_q)
      StIdle: begin
        if (swap_req) begin
          if (swap_point) begin
            do_swap = 1'b1;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (swap_point) begin
          do_swap = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      front_buf_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      swap_done_q <= do_swap;
      if (do_swap) begin
        front_buf_q <= ~front_buf_q;
      end
    end
  end

  assign front_buf = front_buf_q;
  assign swap_done = swap_done_q;

  logic [2:0] sync_dly;

  vga_sync_delay #(
    .WIDTH     (3),
    .STAGES    (2),
    .RESET_VAL (3'b001)
  ) u_sync_delay (
    .clk  (pixel_clk),
    .rst  (rst),
    .din  ({HS_in, VS_in, blank}),
    .dout (sync_dly)
  );

  assign HS        = sync_dly[2];
  assign VS        = sync_dly[1];
  assign blank_out = sync_dly[0];
  assign rgb       = blank_out ? '0 : rgb_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: vector table for arbitration plus
// hand-written sequences for latency, write streaming, swaps and reset.
module tb_vga_fb_arbiter;

  localparam int unsigned DW = 8;

  logic          pixel_clk = 1'b0;
  logic          rst;
  logic [10:0]   hcounter, vcounter;
  logic          blank, HS_in, VS_in;
  logic          wr_valid, wr_ready;
  logic [14:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req, swap_done, front_buf;
  logic [15:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata, rgb;
  logic          HS, VS, blank_out;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_fb_arbiter dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .hcounter  (hcounter),
    .vcounter  (vcounter),
    .blank     (blank),
    .HS_in     (HS_in),
    .VS_in     (VS_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .front_buf (front_buf),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rgb       (rgb),
    .HS        (HS),
    .VS        (VS),
    .blank_out (blank_out)
  );

  always @(negedge pixel_clk) if (swap_done === 1'b1) done_cnt++;

  typedef struct {
    logic        blank;
    logic [10:0] h;
    logic [10:0] v;
    logic        wv;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic        ready;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    int base;
    int nxt;
    logic slot;

    tbl[0] = '{1'b0, 11'd8,   11'd4,   1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 16'h00A2, 8'h00};
    tbl[1] = '{1'b0, 11'd9,   11'd4,   1'b1, 15'd5,     8'h33, 1'b1, 1'b1, 16'h8005, 8'h33};
    tbl[2] = '{1'b0, 11'd10,  11'd4,   1'b0, 15'd0,     8'h00, 1'b1, 1'b0, 16'h8005, 8'h33};
    tbl[3] = '{1'b0, 11'd12,  11'd4,   1'b1, 15'd7,     8'h44, 1'b0, 1'b0, 16'h00A3, 8'h33};
    tbl[4] = '{1'b1, 11'd0,   11'd4,   1'b1, 15'd19200, 8'h55, 1'b1, 1'b0, 16'h00A3, 8'h33};
    tbl[5] = '{1'b1, 11'd640, 11'd480, 1'b1, 15'd19199, 8'h11, 1'b1, 1'b1, 16'hCAFF, 8'h11};
    tbl[6] = '{1'b0, 11'd636, 11'd476, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 16'h4AFF, 8'h11};
    tbl[7] = '{1'b0, 11'd4,   11'd8,   1'b1, 15'd3,     8'h66, 1'b0, 1'b0, 16'h0141, 8'h11};
    tbl[8] = '{1'b1, 11'd4,   11'd8,   1'b0, 15'd0,     8'h00, 1'b1, 1'b0, 16'h0141, 8'h11};
    tbl[9] = '{1'b0, 11'd601, 11'd10,  1'b1, 15'h1234,  8'hA5, 1'b1, 1'b1, 16'h9234, 8'hA5};

    // Reset with a scan slot and active syncs presented.
    rst = 1'b1; blank = 1'b0; hcounter = 11'd8; vcounter = 11'd4;
    HS_in = 1'b1; VS_in = 1'b1; wr_valid = 1'b1; wr_addr = 15'd1; wr_data = 8'h77;
    swap_req = 1'b0; mem_rdata = 8'h99;
    #2;
    check("rst_front_buf", front_buf, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rgb", rgb, 0);
    check("rst_HS", HS, 0);
    check("rst_VS", VS, 0);
    check("rst_blank_out", blank_out, 1);
    tick(); tick();
    check("rst_HS_held", HS, 0);

    // Read latency and sync alignment.
    rst = 1'b0; HS_in = 1'b0; VS_in = 1'b0; wr_valid = 1'b0;
    blank = 1'b0; vcounter = 11'd4; hcounter = 11'd6; tick();
    hcounter = 11'd7; tick();
    hcounter = 11'd8; HS_in = 1'b1; #1;
    check("slot_addr", mem_addr, 16'h00A2);
    check("slot_we", mem_we, 0);
    tick();
    hcounter = 11'd9; HS_in = 1'b0; mem_rdata = 8'h5A; #1;
    check("HS_early", HS, 0);
    tick();
    hcounter = 11'd10; mem_rdata = 8'hFF; #1;
    check("rgb_latency", rgb, 8'h5A);
    check("HS_align", HS, 1);
    tick();
    hcounter = 11'd11; mem_rdata = 8'hEE; #1;
    check("rgb_hold", rgb, 8'h5A);
    check("HS_late", HS, 0);
    tick();
    hcounter = 11'd12; blank = 1'b1; tick();
    hcounter = 11'd13; tick();
    hcounter = 11'd14; #1;
    check("blank_out_delay", blank_out, 1);
    check("rgb_blanked", rgb, 0);
    tick();

    // Vector table: arbitration, addressing, out-of-range drop.
    for (int i = 0; i < 10; i++) begin
      blank = tbl[i].blank; hcounter = tbl[i].h; vcounter = tbl[i].v;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      #1;
      check($sformatf("vec%0d_ready", i), wr_ready, tbl[i].ready);
      check($sformatf("vec%0d_we", i), mem_we, tbl[i].we);
      check($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
      check($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].wdata);
      tick();
    end

    // Streamed writes during active video: nothing lost across scan slots.
    nxt = 0;
    blank = 1'b0; vcounter = 11'd12; wr_valid = 1'b1;
    for (int c = 0; c < 40 && nxt < 8; c++) begin
      hcounter = 11'(16 + c); wr_addr = 15'(nxt); wr_data = 8'(8'hC0 + nxt);
      #1;
      slot = (hcounter[1:0] == 2'b00);
      check("stream_ready", wr_ready, !slot);
      check("stream_we", mem_we, !slot);
      if (!slot) check("stream_addr", mem_addr, 16'h8000 + 16'(nxt));
      if (wr_ready) nxt++;
      tick();
    end
    check("stream_count", nxt, 8);
    wr_valid = 1'b0;

    // Swap: two requests in one frame produce one swap at (480,0).
    base = done_cnt;
    blank = 1'b1; hcounter = 11'd5; vcounter = 11'd100; swap_req = 1'b1; tick();
    swap_req = 1'b0; #1;
    check("swap_pending_fb", front_buf, 0);
    vcounter = 11'd200; swap_req = 1'b1; tick();
    swap_req = 1'b0;
    vcounter = 11'd479; hcounter = 11'd799; tick();
    check("swap_no_early", front_buf, 0);
    vcounter = 11'd480; hcounter = 11'd0; tick();
    check("swap_fb", front_buf, 1);
    check("swap_done_pulse", swap_done, 1);
    hcounter = 11'd1; tick();
    check("swap_done_clear", swap_done, 0);
    vcounter = 11'd10; hcounter = 11'd5; tick();
    vcounter = 11'd480; hcounter = 11'd0; tick();
    check("swap_no_retoggle", front_buf, 1);
    hcounter = 11'd1; tick();
    check("swap_done_count", done_cnt - base, 1);

    // Buffer roles follow front_buf.
    blank = 1'b0; vcounter = 11'd4; hcounter = 11'd8; #1;
    check("fb1_scan_addr", mem_addr, 16'h80A2);
    tick();
    hcounter = 11'd9; wr_valid = 1'b1; wr_addr = 15'd1; wr_data = 8'h3C; #1;
    check("fb1_wr_addr", mem_addr, 16'h0001);
    tick();
    wr_valid = 1'b0; blank = 1'b1;

    // Coincident request swaps immediately (twice: 1->0->1).
    vcounter = 11'd480; hcounter = 11'd0; swap_req = 1'b1; tick();
    swap_req = 1'b0; hcounter = 11'd1;
    check("coinc_fb", front_buf, 0);
    check("coinc_done", swap_done, 1);
    tick();
    hcounter = 11'd0; swap_req = 1'b1; tick();
    swap_req = 1'b0; hcounter = 11'd1;
    check("coinc2_fb", front_buf, 1);
    tick();

    // Reset with a swap pending aborts it.
    vcounter = 11'd100; hcounter = 11'd5; swap_req = 1'b1; tick();
    swap_req = 1'b0; vcounter = 11'd300; tick();
    blank = 1'b0; vcounter = 11'd4; hcounter = 11'd8; rst = 1'b1; #1;
    check("rst_mid_fb", front_buf, 0);
    check("rst_mid_rgb", rgb, 0);
    check("rst_mid_blank_out", blank_out, 1);
    check("rst_mid_addr", mem_addr, 0);
    tick();
    rst = 1'b0; #1;
    check("resume_scan_addr", mem_addr, 16'h00A2);
    tick();
    base = done_cnt;
    blank = 1'b1; vcounter = 11'd480; hcounter = 11'd0; tick();
    hcounter = 11'd1;
    check("rst_abort_fb", front_buf, 0);
    tick();
    check("rst_abort_done", done_cnt - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in pixels (640/4).
REQ-002 Parameter FB_H, default 120, framebuffer height in pixels (480/4).
REQ-003 Parameter DW, default 8, pixel data width (RGB332).
REQ-004 pixel_clk  in  1  the block's only clock, all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 hcounter  in  11  horizontal count from the VGA timing generator, 0..799.
REQ-007 vcounter  in  11  vertical count from the VGA timing generator, 0..524.
REQ-008 blank  in  1  high outside the 640x480 active area.
REQ-009 HS_in, VS_in  in  1 each  syncs from the timing generator.
REQ-010 wr_valid  in  1  draw engine write request.
REQ-011 wr_ready  out  1  write slot available this cycle.
REQ-012 wr_addr  in  15  back-buffer pixel index, y*FB_W+x.
REQ-013 wr_data  in  DW  pixel to write.
REQ-014 swap_req  in  1  one-cycle pulse requesting a front/back buffer swap.
REQ-015 swap_done  out  1  one-cycle pulse when the swap takes effect.
REQ-016 front_buf  out  1  index of the buffer being scanned out.
REQ-017 mem_addr  out  16  RAM address, {buffer bit, 15-bit index}.
REQ-018 mem_we  out  1  RAM write enable.
REQ-019 mem_wdata  out  DW  RAM write data.
REQ-020 mem_rdata  in  DW  synchronous RAM read data, valid one cycle after the address.
REQ-021 rgb  out  DW  scanout pixel.
REQ-022 HS, VS, blank_out  out  1 each  syncs and blank delayed to align with rgb.

Function
REQ-023 Scan slot: active in a cycle where blank==0 and hcounter[1:0]==0; mem_addr={front_buf,(vcounter>>2)*FB_W+(hcounter>>2)} and mem_we=0.
REQ-024 The multiply is implemented as shift-add, (y<<7)+(y<<5)+x, 15 bits, with no truncation for y<120 and x<160.
REQ-025 wr_ready is 1 in every cycle that is not a scan slot; it is combinational from blank/hcounter and never depends on wr_valid.
REQ-026 Write acceptance: wr_valid & wr_ready; that cycle drives mem_addr={~front_buf,wr_addr}, mem_we=1 and mem_wdata=wr_data.
REQ-027 An accepted write with wr_addr >= FB_W*FB_H is consumed with mem_we=0 (dropped, no wrap).
REQ-028 When no scan slot is active and no write is accepted, mem_we=0 and mem_addr holds its previous value.
REQ-029 rgb latency: mem_rdata is registered in the cycle after a scan slot, so rgb changes 2 cycles after the slot and holds for 4 pixels.
REQ-030 Blank output: rgb=0 whenever the 2-cycle-delayed blank is 1.
REQ-031 HS, VS and blank_out are HS_in, VS_in and blank each delayed by exactly 2 registers.
REQ-032 Swap FSM has two states: IDLE and PENDING.
REQ-033 In IDLE, swap_req moves the FSM to PENDING.
REQ-034 In PENDING, at the swap point (vcounter==480 and hcounter==0), front_buf toggles, swap_done pulses for 1 cycle, and the FSM returns to IDLE.
REQ-035 If swap_req arrives in IDLE in the same cycle as the swap point, the swap happens that cycle.
REQ-036 swap_req while PENDING is ignored, so at most one swap happens per frame.
REQ-037 front_buf never changes outside the swap point, so no frame is ever scanned from mixed buffers.

Reset
REQ-038 While rst is high: FSM=IDLE, front_buf=0, swap_done=0, mem_we=0, mem_addr=0, mem_wdata=0, rgb=0, HS=0, VS=0, blank_out=1, and all delay registers are cleared.
REQ-039 Reset mid-frame aborts any pending swap; scanout resumes at the next scan slot after release, with no resynchronisation wait.

Structure
REQ-040 A shared package holds FB_W, FB_H, DW, the swap-point constants (480, 0) and the FSM state encodings (IDLE=0, PENDING=1).
REQ-041 One sub-module, vga_sync_delay, implements the generic N-stage delay line used for HS/VS/blank; everything else is flat.

Verification
REQ-042 Scan slot timing: blank=0, hcounter=8, vcounter=4 -> mem_addr=0x00A2 (index 162, front_buf=0) and mem_we=0; mem_rdata=0x5A in the next cycle -> rgb=0x5A in the cycle after that.
REQ-043 Write arbitration: wr_valid held high with addresses 0..7 during active video -> wr_ready=0 on every hcounter[1:0]==0 cycle, writes go to buffer 1 at mem_addr 0x8000..0x8007, and none are lost.
REQ-044 Out-of-range write: wr_addr=19200 with wr_valid=1 -> wr_ready=1 and mem_we=0.
REQ-045 Swap: swap_req at vcounter=100, a second swap_req at vcounter=200 -> exactly one swap_done at (480,0), front_buf goes 0->1, and there is no further toggle next frame.
REQ-046 Coincident swap and reset: swap_req at (480,0) -> swap happens that cycle; rst asserted at vcounter=300 with a swap pending -> front_buf=0, rgb=0, blank_out=1, and no swap at the next (480,0).
